// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush/redirect decode over a RUN/DRAIN FSM.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_busy_i,
    input  logic        if_mem_busy_i,
    input  logic        id_loaduse_i,
    input  logic        ex_branch_i,
    input  logic [31:0] ex_branch_target_i,
    output logic [5:0]  stall_o,
    output logic        if_idflush_o,
    output logic        id_exflush_o,
    output logic        pc_redirect_o,
    output logic [31:0] pc_target_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] redirects_o
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [5:0]  stall_s;
    logic        if_idflush_s;
    logic        id_exflush_s;
    logic        pc_redirect_s;
    logic [31:0] pc_target_s;

    // Prioritised hazard decode; reset forces every control output low.
    always_comb begin
        state_next_s  = state_r;
        stall_s       = 6'b000000;
        if_idflush_s  = 1'b0;
        id_exflush_s  = 1'b0;
        pc_redirect_s = 1'b0;
        pc_target_s   = 32'h0000_0000;
        if (!rst) begin
            state_next_s = ST_RUN;
        end else if (mem_busy_i) begin
            // Held EX re-presents any branch once MEM completes, so ignore it here.
            stall_s      = 6'b011111;
            state_next_s = state_r;
        end else if (ex_branch_i) begin
            pc_redirect_s = 1'b1;
            pc_target_s   = ex_branch_target_i;
            if_idflush_s  = 1'b1;
            id_exflush_s  = 1'b1;
            state_next_s  = if_mem_busy_i ? ST_DRAIN : ST_RUN;
        end else if (state_r == ST_DRAIN) begin
            // Wrong-path fetch still returning: keep discarding until it lands.
            stall_s      = 6'b000001;
            if_idflush_s = 1'b1;
            state_next_s = if_mem_busy_i ? ST_DRAIN : ST_RUN;
        end else if (id_loaduse_i) begin
            stall_s      = 6'b000111;
            id_exflush_s = 1'b1;
        end else if (if_mem_busy_i) begin
            stall_s      = 6'b000001;
            if_idflush_s = 1'b1;
        end else begin
            state_next_s = ST_RUN;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign stall_o       = stall_s;
    assign if_idflush_o  = if_idflush_s;
    assign id_exflush_o  = id_exflush_s;
    assign pc_redirect_o = pc_redirect_s;
    assign pc_target_o   = pc_target_s;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] redirect_cnt_r;

    // Saturating event counters for stalled and redirected cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r    <= 32'h0000_0000;
            redirect_cnt_r <= 32'h0000_0000;
        end else begin
            if ((stall_s != 6'b000000) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (pc_redirect_s && (redirect_cnt_r != 32'hFFFF_FFFF)) begin
                redirect_cnt_r <= redirect_cnt_r + 32'h0000_0001;
            end else begin
                redirect_cnt_r <= redirect_cnt_r;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_r;
    assign redirects_o    = redirect_cnt_r;
`else
    assign stall_cycles_o = 32'h0000_0000;
    assign redirects_o    = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected control outputs are queued per vector
// and compared mid-cycle; counters are checked against PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_busy_i;
    logic        if_mem_busy_i;
    logic        id_loaduse_i;
    logic        ex_branch_i;
    logic [31:0] ex_branch_target_i;
    logic [5:0]  stall_o;
    logic        if_idflush_o;
    logic        id_exflush_o;
    logic        pc_redirect_o;
    logic [31:0] pc_target_o;
    logic [31:0] stall_cycles_o;
    logic [31:0] redirects_o;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [5:0]  stall;
        logic        ifl;
        logic        exfl;
        logic        redir;
        logic [31:0] tgt;
    } exp_t;

    typedef struct packed {
        logic        mb;
        logic        ifb;
        logic        lu;
        logic        br;
        logic [31:0] tgt;
        exp_t        e;
    } vec_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .mem_busy_i         (mem_busy_i),
        .if_mem_busy_i      (if_mem_busy_i),
        .id_loaduse_i       (id_loaduse_i),
        .ex_branch_i        (ex_branch_i),
        .ex_branch_target_i (ex_branch_target_i),
        .stall_o            (stall_o),
        .if_idflush_o       (if_idflush_o),
        .id_exflush_o       (id_exflush_o),
        .pc_redirect_o      (pc_redirect_o),
        .pc_target_o        (pc_target_o),
        .stall_cycles_o     (stall_cycles_o),
        .redirects_o        (redirects_o)
    );

    function automatic vec_t mk(input logic mb, input logic ifb, input logic lu, input logic br,
                                input logic [31:0] tgt, input logic [5:0] st, input logic ifl,
                                input logic exfl, input logic redir, input logic [31:0] etgt);
        vec_t v;
        v.mb = mb; v.ifb = ifb; v.lu = lu; v.br = br; v.tgt = tgt;
        v.e.stall = st; v.e.ifl = ifl; v.e.exfl = exfl; v.e.redir = redir; v.e.tgt = etgt;
        return v;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.stall = stall_o; o.ifl = if_idflush_o; o.exfl = id_exflush_o;
        o.redir = pc_redirect_o; o.tgt = pc_target_o;
        return o;
    endfunction

    // Drive one vector just after the rising edge, queue its expectation, wait to mid-cycle.
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        mem_busy_i = v.mb; if_mem_busy_i = v.ifb; id_loaduse_i = v.lu;
        ex_branch_i = v.br; ex_branch_target_i = v.tgt;
        sb_q.push_back(v.e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        vec_t v[3];
        exp_t e, got;
        rst = 1'b0;
        v[0] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        v[1] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        v[2] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            apply(v[i]);
            e = sb_q.pop_front(); got = observe(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %h, expected %h", i, got, e);
            end
        end
        vectors++;
        if (stall_cycles_o !== 32'h0 || redirects_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_counters: got %h/%h, expected 0/0", stall_cycles_o, redirects_o);
        end
        mem_busy_i = 1'b0; if_mem_busy_i = 1'b0; id_loaduse_i = 1'b0; ex_branch_i = 1'b0;
        #1 rst = 1'b1;
    endtask

    task automatic test_branch();
        vec_t v[5];
        exp_t e, got;
        v[0] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        v[1] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        v[2] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        v[3] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 6'b000000, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        v[4] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            apply(v[i]);
            e = sb_q.pop_front(); got = observe(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL branch[%0d]: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_drain();
        vec_t v[7];
        exp_t e, got;
        v[0] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        v[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         6'b000001, 1'b1, 1'b0, 1'b0, 32'h0);
        v[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         6'b000001, 1'b1, 1'b0, 1'b0, 32'h0);
        v[3] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         6'b000001, 1'b1, 1'b0, 1'b0, 32'h0);
        v[4] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000001, 1'b1, 1'b0, 1'b0, 32'h0);
        v[5] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        v[6] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         6'b000111, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            apply(v[i]);
            e = sb_q.pop_front(); got = observe(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL drain[%0d]: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_mem_busy();
        vec_t v[8];
        exp_t e, got;
        v[0] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 6'b011111, 1'b0, 1'b0, 1'b0, 32'h0);
        v[1] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 6'b011111, 1'b0, 1'b0, 1'b0, 32'h0);
        v[2] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
        v[3] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        v[4] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0A00, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_0A00);
        v[5] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         6'b011111, 1'b0, 1'b0, 1'b0, 32'h0);
        v[6] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000001, 1'b1, 1'b0, 1'b0, 32'h0);
        v[7] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            apply(v[i]);
            e = sb_q.pop_front(); got = observe(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL mem_busy[%0d]: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_hazards();
        vec_t v[4];
        exp_t e, got;
        v[0] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000111, 1'b0, 1'b1, 1'b0, 32'h0);
        v[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'b000001, 1'b1, 1'b0, 1'b0, 32'h0);
        v[2] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 6'b000111, 1'b0, 1'b1, 1'b0, 32'h0);
        v[3] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            apply(v[i]);
            e = sb_q.pop_front(); got = observe(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL hazards[%0d]: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[8];
        exp_t e, got;
        v[0] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_1000);
        v[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         6'b000001, 1'b1, 1'b0, 1'b0, 32'h0);
        v[2] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_2000);
        v[3] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000001, 1'b1, 1'b0, 1'b0, 32'h0);
        v[4] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_3000);
        v[5] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_4000);
        v[6] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        v[7] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            apply(v[i]);
            e = sb_q.pop_front(); got = observe(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        vec_t v[2];
        vec_t z;
        exp_t e, got;
        v[0] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_0400);
        v[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         6'b000001, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            apply(v[i]);
            e = sb_q.pop_front(); got = observe(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL mid_drain_setup[%0d]: got %h, expected %h", i, got, e);
            end
        end
        // Assert reset between edges: outputs must drop with no clock.
        #2 rst = 1'b0;
        z = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        sb_q.push_back(z.e);
        #1;
        e = sb_q.pop_front(); got = observe(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL async_reset: got %h, expected %h", got, e);
        end
        apply(z);
        e = sb_q.pop_front(); got = observe(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset_held: got %h, expected %h", got, e);
        end
        if_mem_busy_i = 1'b0;
        #1 rst = 1'b1;
        z = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            apply(z);
            e = sb_q.pop_front(); got = observe(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL post_reset_run[%0d]: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_perf();
        vec_t v[9];
        exp_t e, got;
        logic [31:0] exp_stalls, exp_redirs;
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        v[0] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         6'b000111, 1'b0, 1'b1, 1'b0, 32'h0);
        v[1] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         6'b000111, 1'b0, 1'b1, 1'b0, 32'h0);
        v[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         6'b000001, 1'b1, 1'b0, 1'b0, 32'h0);
        v[3] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 6'b011111, 1'b0, 1'b0, 1'b0, 32'h0);
        v[4] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         6'b011111, 1'b0, 1'b0, 1'b0, 32'h0);
        v[5] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_0500);
        v[6] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        v[7] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0600, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_0600);
        v[8] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            apply(v[i]);
            e = sb_q.pop_front(); got = observe(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL perf_seq[%0d]: got %h, expected %h", i, got, e);
            end
        end
`ifdef PIPE_CTRL_PERF_EN
        exp_stalls = 32'd5;
        exp_redirs = 32'd2;
`else
        exp_stalls = 32'd0;
        exp_redirs = 32'd0;
`endif
        vectors++;
        if (stall_cycles_o !== exp_stalls) begin
            miscompares++;
            $display("FAIL stall_cycles: got %0d, expected %0d", stall_cycles_o, exp_stalls);
        end
        vectors++;
        if (redirects_o !== exp_redirs) begin
            miscompares++;
            $display("FAIL redirects: got %0d, expected %0d", redirects_o, exp_redirs);
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_busy_i = 1'b0; if_mem_busy_i = 1'b0; id_loaduse_i = 1'b0;
        ex_branch_i = 1'b0; ex_branch_target_i = 32'h0;
        test_reset();
        test_branch();
        test_drain();
        test_mem_busy();
        test_hazards();
        test_back_to_back();
        test_reset_mid_drain();
        test_perf();
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
